// File: rtl/photonic_link_tx.sv
// Transmit side of the photonic node link: arbitrates for the shared waveguide, sends a
// header flit with the destination ID, then the payload MSB-first; self-addressed frames loop back.
module photonic_link_tx #(
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 2,
    parameter int NODE_ID    = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [ID_WIDTH-1:0]   tx_dest,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_done,
    output logic                  link_req,
    input  logic                  link_grant,
    output logic                  link_valid,
    output logic                  link_sof,
    output logic [LANE_WIDTH-1:0] link_data,
    output logic                  loop_valid,
    output logic [DATA_WIDTH-1:0] loop_data
);

    localparam int BEATS  = (DATA_WIDTH / LANE_WIDTH < 1) ? 1 : DATA_WIDTH / LANE_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ID_WIDTH-1:0]   dest_q, dest_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  new_is_local;
    logic                  held_is_local;
    logic [DATA_WIDTH-1:0] data_aligned;

    assign new_is_local  = (tx_dest == ID_WIDTH'(NODE_ID));
    assign held_is_local = (dest_q == ID_WIDTH'(NODE_ID));
    // The held payload stays intact for loopback, so the current flit is selected by shifting a copy.
    assign data_aligned  = data_q << (32'(beat_q) * LANE_WIDTH);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        beat_d     = beat_q;
        dest_d     = dest_q;
        data_d     = data_q;
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        link_req   = 1'b0;
        link_valid = 1'b0;
        link_sof   = 1'b0;
        link_data  = '0;
        loop_valid = 1'b0;
        loop_data  = '0;

        case (state_q)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    dest_d  = tx_dest;
                    data_d  = tx_data;
                    beat_d  = '0;
                    state_d = new_is_local ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                link_req = 1'b1;
                if (link_grant) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                link_req   = 1'b1;
                link_valid = 1'b1;
                link_sof   = 1'b1;
                link_data  = LANE_WIDTH'(dest_q);
                beat_d     = '0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                // Once the header is out the frame runs to completion regardless of grant.
                link_req   = 1'b1;
                link_valid = 1'b1;
                link_data  = data_aligned[DATA_WIDTH-1 -: LANE_WIDTH];
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_DONE: begin
                tx_done = 1'b1;
                if (held_is_local) begin
                    loop_valid = 1'b1;
                    loop_data  = data_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_photonic_link_tx.sv
// Self-checking bench for photonic_link_tx: table-driven frames, hand-written corner
// sequences (back-to-back in DONE, mid-frame reset) and random frames against a frame-level model.
module tb_photonic_link_tx;

    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 8;
    localparam int LANE_WIDTH = 2;
    localparam int NODE_ID    = 0;
    localparam int BEATS      = DATA_WIDTH / LANE_WIDTH;

    logic                  clk;
    logic                  reset_n;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [ID_WIDTH-1:0]   tx_dest;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_done;
    logic                  link_req;
    logic                  link_grant;
    logic                  link_valid;
    logic                  link_sof;
    logic [LANE_WIDTH-1:0] link_data;
    logic                  loop_valid;
    logic [DATA_WIDTH-1:0] loop_data;

    photonic_link_tx #(
        .ID_WIDTH  (ID_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LANE_WIDTH(LANE_WIDTH),
        .NODE_ID   (NODE_ID)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_dest   (tx_dest),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .link_req  (link_req),
        .link_grant(link_grant),
        .link_valid(link_valid),
        .link_sof  (link_sof),
        .link_data (link_data),
        .loop_valid(loop_valid),
        .loop_data (loop_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       req;
        logic       valid;
        logic       sof;
        logic [1:0] ldata;
        logic       done;
        logic       lvalid;
        logic [7:0] lpdata;
    } out_t;

    typedef struct {
        logic [1:0]       dest;
        logic [7:0]       data;
        int               gdelay;
        int               drop_at;
        logic [0:3][1:0]  flits;
        string            name;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic out_t mk(logic ready, logic req, logic valid, logic sof, logic [1:0] ld,
                                logic done, logic lv, logic [7:0] lp);
        out_t o;
        o.ready  = ready;
        o.req    = req;
        o.valid  = valid;
        o.sof    = sof;
        o.ldata  = ld;
        o.done   = done;
        o.lvalid = lv;
        o.lpdata = lp;
        return o;
    endfunction

    function automatic out_t idle_out();
        return mk(1, 0, 0, 0, 2'd0, 0, 0, 8'h00);
    endfunction

    // Reference: flit i of a payload is the i-th LANE_WIDTH slice counted from the MSB.
    function automatic logic [0:3][1:0] model_flits(logic [7:0] data);
        logic [0:3][1:0] f;
        for (int i = 0; i < BEATS; i++) begin
            f[i] = 2'((data >> (DATA_WIDTH - LANE_WIDTH * (i + 1))) % (1 << LANE_WIDTH));
        end
        return f;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = mk(tx_ready, link_req, link_valid, link_sof, link_data, tx_done, loop_valid, loop_data);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b req=%b val=%b sof=%b ld=%h done=%b lv=%b lp=%h, want rdy=%b req=%b val=%b sof=%b ld=%h done=%b lv=%b lp=%h",
                     name, act.ready, act.req, act.valid, act.sof, act.ldata, act.done, act.lvalid, act.lpdata,
                     exp.ready, exp.req, exp.valid, exp.sof, exp.ldata, exp.done, exp.lvalid, exp.lpdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from IDLE and checks every cycle until IDLE again.
    // gdelay: grant rises in the gdelay-th REQ cycle; drop_at: grant falls from that data flit on.
    task automatic run_frame(input logic [1:0] dest, input logic [7:0] data, input int gdelay,
                             input int drop_at, input logic [0:3][1:0] flits, input string name);
        check({name, ":idle"}, idle_out());
        tx_valid   = 1'b1;
        tx_dest    = dest;
        tx_data    = data;
        link_grant = 1'b0;
        step();
        tx_valid = 1'b0;
        tx_dest  = 2'($urandom);
        tx_data  = 8'($urandom);
        if (dest == 2'(NODE_ID)) begin
            check({name, ":loop"}, mk(0, 0, 0, 0, 2'd0, 1, 1, data));
            step();
        end else begin
            for (int j = 0; j <= gdelay; j++) begin
                link_grant = (j >= gdelay);
                check({name, ":req"}, mk(0, 1, 0, 0, 2'd0, 0, 0, 8'h00));
                step();
            end
            check({name, ":hdr"}, mk(0, 1, 1, 1, dest, 0, 0, 8'h00));
            step();
            for (int i = 0; i < BEATS; i++) begin
                link_grant = !(drop_at >= 0 && i >= drop_at);
                check($sformatf("%s:flit%0d", name, i), mk(0, 1, 1, 0, flits[i], 0, 0, 8'h00));
                step();
            end
            link_grant = 1'b0;
            check({name, ":done"}, mk(0, 0, 0, 0, 2'd0, 1, 0, 8'h00));
            step();
        end
        check({name, ":after"}, idle_out());
    endtask

    vec_t vecs[8];

    initial begin
        logic [1:0] rd;
        logic [7:0] rdat;
        int         rg;
        int         rdrop;

        vecs[0] = '{2'd2, 8'hB4, 0, -1, {2'd2, 2'd3, 2'd1, 2'd0}, "grant_tied"};
        vecs[1] = '{2'd2, 8'hB4, 4, -1, {2'd2, 2'd3, 2'd1, 2'd0}, "grant_late"};
        vecs[2] = '{2'd0, 8'h5A, 0, -1, {2'd0, 2'd0, 2'd0, 2'd0}, "loopback"};
        vecs[3] = '{2'd2, 8'hB4, 0, 1,  {2'd2, 2'd3, 2'd1, 2'd0}, "grant_drop"};
        vecs[4] = '{2'd3, 8'h0F, 2, 0,  {2'd0, 2'd0, 2'd3, 2'd3}, "drop_first"};
        vecs[5] = '{2'd1, 8'hC6, 1, -1, {2'd3, 2'd0, 2'd1, 2'd2}, "dest1"};
        vecs[6] = '{2'd3, 8'hFF, 0, -1, {2'd3, 2'd3, 2'd3, 2'd3}, "all_ones"};
        vecs[7] = '{2'd1, 8'h00, 3, 2,  {2'd0, 2'd0, 2'd0, 2'd0}, "zeros"};

        reset_n    = 1'b0;
        tx_valid   = 1'b0;
        tx_dest    = '0;
        tx_data    = '0;
        link_grant = 1'b0;

        #3;
        check("reset_hold", idle_out());
        tx_valid   = 1'b1;
        tx_dest    = 2'd2;
        link_grant = 1'b1;
        step();
        check("reset_hold_stim", idle_out());
        tx_valid   = 1'b0;
        link_grant = 1'b0;
        reset_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_quiet", idle_out());
        end

        foreach (vecs[i]) begin
            run_frame(vecs[i].dest, vecs[i].data, vecs[i].gdelay, vecs[i].drop_at,
                      vecs[i].flits, vecs[i].name);
        end

        // tx_valid raised during DONE must wait for the IDLE cycle.
        check("b2b:idle", idle_out());
        tx_valid = 1'b1;
        tx_dest  = 2'd0;
        tx_data  = 8'h11;
        step();
        tx_data = 8'h22;
        check("b2b:done1", mk(0, 0, 0, 0, 2'd0, 1, 1, 8'h11));
        step();
        check("b2b:idle_gap", idle_out());
        step();
        tx_valid = 1'b0;
        check("b2b:done2", mk(0, 0, 0, 0, 2'd0, 1, 1, 8'h22));
        step();
        check("b2b:after", idle_out());

        // Reset mid-frame during data beat 1 drops the link at once.
        tx_valid = 1'b1;
        tx_dest  = 2'd3;
        tx_data  = 8'hC9;
        step();
        tx_valid   = 1'b0;
        link_grant = 1'b1;
        check("rst:req", mk(0, 1, 0, 0, 2'd0, 0, 0, 8'h00));
        step();
        check("rst:hdr", mk(0, 1, 1, 1, 2'd3, 0, 0, 8'h00));
        step();
        check("rst:flit0", mk(0, 1, 1, 0, 2'd3, 0, 0, 8'h00));
        step();
        check("rst:flit1", mk(0, 1, 1, 0, 2'd0, 0, 0, 8'h00));
        #1 reset_n = 1'b0;
        #1;
        check("rst:async_drop", idle_out());
        #1 reset_n = 1'b1;
        step();
        check("rst:released", idle_out());
        run_frame(2'd2, 8'hB4, 0, -1, model_flits(8'hB4), "rst:next_frame");

        for (int n = 0; n < 40; n++) begin
            rd    = 2'($urandom_range(0, 3));
            rdat  = 8'($urandom);
            rg    = int'($urandom_range(0, 5));
            rdrop = int'($urandom_range(0, 4)) - 1;
            run_frame(rd, rdat, rg, rdrop, model_flits(rdat), $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
